packet_fifo: RTL and testbench



---
 rtl/packet_fifo_pkg.sv | 18 +
 rtl/simple_dual_port_ram.sv | 30 +++
 rtl/packet_fifo.sv | 154 +++++++++++++++
 tb/tb_packet_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_fifo_pkg.sv
// packet_fifo_pkg: shared helpers for the store-and-forward packet FIFO.
//   DEFAULT_DATA_WIDTH / DEFAULT_DATA_DEPTH : parameter defaults for packet_fifo
//   ptr_diff()                              : modulo pointer distance
package packet_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_DATA_DEPTH = 4096;

  // Distance a - b for pointers that are 'width' bits wide. The wrap bit
  // (pointer MSB) is included, so the result ranges over 0..2^(width-1).
  function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/simple_dual_port_ram.sv
// simple_dual_port_ram: one write port, one registered read port, no reset.
//   clk_i   : clock
//   we_i    : write strobe, waddr_i / wdata_i : write address / word
//   re_i    : read strobe,  raddr_i           : read address
//   rdata_o : read word, updated only on the edge where re_i is high
module simple_dual_port_ram #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 8,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/packet_fifo.sv
// packet_fifo: store-and-forward packet FIFO. Only committed packets are visible
// to the read side; a packet can be aborted (write_drop) or dropped on overflow.
//   clock, reset (sync, active-high)
//   write_enable/write_data/write_last/write_drop : write side
//   read_enable -> read_data/read_last/read_data_valid (1-cycle latency)
//   full, empty, almost_full, almost_empty, fill_count, packet_count : status
//   dropped_packet : one-cycle pulse when a packet is discarded
module packet_fifo
  import packet_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH             = DEFAULT_DATA_WIDTH,
  parameter int unsigned DATA_DEPTH             = DEFAULT_DATA_DEPTH,
  parameter int unsigned ALMOST_FULL_THRESHOLD  = DATA_DEPTH - 16,
  parameter int unsigned ALMOST_EMPTY_THRESHOLD = 16,
  parameter int unsigned ADDRESS_WIDTH          = $clog2(DATA_DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    write_enable,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic                    write_last,
  input  logic                    write_drop,
  input  logic                    read_enable,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_last,
  output logic                    read_data_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ADDRESS_WIDTH:0]  fill_count,
  output logic [ADDRESS_WIDTH:0]  packet_count,
  output logic                    dropped_packet
);

  localparam int unsigned CountW = ADDRESS_WIDTH + 1;

  typedef logic [ADDRESS_WIDTH:0] ptr_t;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } mem_word_t;

  ptr_t read_pointer_q, read_pointer_d;
  ptr_t write_pointer_q, write_pointer_d;
  ptr_t commit_pointer_q, commit_pointer_d;
  ptr_t packet_count_q, packet_count_d;
  logic drop_pending_q, drop_pending_d;
  logic dropped_packet_q, dropped_packet_d;
  logic read_data_valid_q, read_data_valid_d;
  logic read_seen_q, read_seen_d;

  logic      read_accept, write_accept, commit, pending_dec;
  mem_word_t wr_word, rd_word;
  ptr_t      fill;

  assign fill         = ptr_t'(ptr_diff(32'(write_pointer_q), 32'(read_pointer_q), CountW));
  assign fill_count   = fill;
  assign full         = (32'(fill) == DATA_DEPTH);
  assign empty        = (read_pointer_q == commit_pointer_q);
  assign almost_full  = (32'(fill) >= ALMOST_FULL_THRESHOLD);
  assign almost_empty = (32'(fill) <= ALMOST_EMPTY_THRESHOLD);

  assign read_accept = read_enable && !empty;

  // The last flag of a read beat is only known once the RAM output register
  // holds it, so the decrement is applied one cycle late in packet_count_q and
  // compensated here to keep packet_count exact on the cycle after the read.
  assign pending_dec  = read_data_valid_q & rd_word.last;
  assign packet_count = packet_count_q - ptr_t'(pending_dec);

  always_comb begin
    write_pointer_d  = write_pointer_q;
    commit_pointer_d = commit_pointer_q;
    drop_pending_d   = drop_pending_q;
    dropped_packet_d = 1'b0;
    write_accept     = 1'b0;
    commit           = 1'b0;

    if (write_drop) begin
      write_pointer_d  = commit_pointer_q;
      dropped_packet_d = 1'b1;
      drop_pending_d   = 1'b0;
    end else if (write_enable) begin
      if (drop_pending_q) begin
        // Swallow the rest of an overflowed packet, including its last beat.
        if (write_last) drop_pending_d = 1'b0;
      end else if (full) begin
        write_pointer_d  = commit_pointer_q;
        dropped_packet_d = 1'b1;
        drop_pending_d   = !write_last;
      end else begin
        write_accept    = 1'b1;
        write_pointer_d = write_pointer_q + ptr_t'(1);
        if (write_last) begin
          commit           = 1'b1;
          commit_pointer_d = write_pointer_q + ptr_t'(1);
        end
      end
    end

    read_pointer_d    = read_accept ? read_pointer_q + ptr_t'(1) : read_pointer_q;
    read_data_valid_d = read_accept;
    read_seen_d       = read_seen_q | read_accept;
    packet_count_d    = packet_count_q + ptr_t'(commit) - ptr_t'(pending_dec);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_pointer_q    <= '0;
      write_pointer_q   <= '0;
      commit_pointer_q  <= '0;
      packet_count_q    <= '0;
      drop_pending_q    <= 1'b0;
      dropped_packet_q  <= 1'b0;
      read_data_valid_q <= 1'b0;
      read_seen_q       <= 1'b0;
    end else begin
      read_pointer_q    <= read_pointer_d;
      write_pointer_q   <= write_pointer_d;
      commit_pointer_q  <= commit_pointer_d;
      packet_count_q    <= packet_count_d;
      drop_pending_q    <= drop_pending_d;
      dropped_packet_q  <= dropped_packet_d;
      read_data_valid_q <= read_data_valid_d;
      read_seen_q       <= read_seen_d;
    end
  end

  assign wr_word.last = write_last;
  assign wr_word.data = write_data;

  simple_dual_port_ram #(
    .Width ($bits(mem_word_t)),
    .Depth (DATA_DEPTH)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (write_accept),
    .waddr_i (write_pointer_q[ADDRESS_WIDTH-1:0]),
    .wdata_i (wr_word),
    .re_i    (read_accept),
    .raddr_i (read_pointer_q[ADDRESS_WIDTH-1:0]),
    .rdata_o (rd_word)
  );

  // The RAM output register has no reset; read_seen_q forces the visible read
  // beat to zero until the first read after reset.
  assign read_data       = rd_word.data & {DATA_WIDTH{read_seen_q}};
  assign read_last       = rd_word.last & read_seen_q;
  assign read_data_valid = read_data_valid_q;
  assign dropped_packet  = dropped_packet_q;

endmodule

// File: tb/tb_packet_fifo.sv
module tb_packet_fifo;

  logic        clock;
  logic        reset;
  logic        write_enable;
  logic [15:0] write_data;
  logic        write_last;
  logic        write_drop;
  logic        read_enable;
  logic [15:0] read_data;
  logic        read_last;
  logic        read_data_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  fill_count;
  logic [3:0]  packet_count;
  logic        dropped_packet;

  int checks;
  int errors;

  packet_fifo #(
    .DATA_WIDTH             (16),
    .DATA_DEPTH             (8),
    .ALMOST_FULL_THRESHOLD  (6),
    .ALMOST_EMPTY_THRESHOLD (2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .write_enable    (write_enable),
    .write_data      (write_data),
    .write_last      (write_last),
    .write_drop      (write_drop),
    .read_enable     (read_enable),
    .read_data       (read_data),
    .read_last       (read_last),
    .read_data_valid (read_data_valid),
    .full            (full),
    .empty           (empty),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .fill_count      (fill_count),
    .packet_count    (packet_count),
    .dropped_packet  (dropped_packet)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_beat(input logic [15:0] data, input logic last);
    write_enable = 1'b1;
    write_data   = data;
    write_last   = last;
    tick();
    write_enable = 1'b0;
    write_last   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
    checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got %0b want 1", almost_empty); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %0b want 0", almost_full); end
    checks++; if (fill_count !== 4'd0) begin errors++; $display("FAIL reset_fill got %0d want 0", fill_count); end
    checks++; if (packet_count !== 4'd0) begin errors++; $display("FAIL reset_pkts got %0d want 0", packet_count); end
    checks++; if (read_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", read_data_valid); end
    checks++; if (read_data !== 16'h0) begin errors++; $display("FAIL reset_rdata got %0h want 0", read_data); end
  endtask

  task automatic test_basic();
    write_beat(16'hA1, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty_a1 got %0b want 1", empty); end
    write_beat(16'hA2, 1'b0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty_a2 got %0b want 1", empty); end
    write_beat(16'hA3, 1'b1);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_empty_a3 got %0b want 0", empty); end
    checks++; if (packet_count !== 4'd1) begin errors++; $display("FAIL basic_pkts got %0d want 1", packet_count); end
    checks++; if (fill_count !== 4'd3) begin errors++; $display("FAIL basic_fill got %0d want 3", fill_count); end
    checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL basic_almost_empty got %0b want 0", almost_empty); end
    read_enable = 1'b1;
    tick();
    checks++; if ({read_data_valid, read_last, read_data} !== {1'b1, 1'b0, 16'hA1})
      begin errors++; $display("FAIL basic_rd1 got v=%0b l=%0b d=%0h want v=1 l=0 d=a1", read_data_valid, read_last, read_data); end
    tick();
    checks++; if ({read_data_valid, read_last, read_data} !== {1'b1, 1'b0, 16'hA2})
      begin errors++; $display("FAIL basic_rd2 got v=%0b l=%0b d=%0h want v=1 l=0 d=a2", read_data_valid, read_last, read_data); end
    tick();
    read_enable = 1'b0;
    checks++; if ({read_data_valid, read_last, read_data} !== {1'b1, 1'b1, 16'hA3})
      begin errors++; $display("FAIL basic_rd3 got v=%0b l=%0b d=%0h want v=1 l=1 d=a3", read_data_valid, read_last, read_data); end
    checks++; if (packet_count !== 4'd0) begin errors++; $display("FAIL basic_pkts_after got %0d want 0", packet_count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty_after got %0b want 1", empty); end
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
    checks++; if ({read_data_valid, read_data} !== {1'b0, 16'hA3})
      begin errors++; $display("FAIL basic_rd_empty got v=%0b d=%0h want v=0 d=a3", read_data_valid, read_data); end
  endtask

  task automatic test_drop();
    write_beat(16'hD1, 1'b0);
    write_beat(16'hD2, 1'b0);
    checks++; if (fill_count !== 4'd2) begin errors++; $display("FAIL drop_fill_before got %0d want 2", fill_count); end
    write_drop   = 1'b1;
    write_enable = 1'b1;
    write_data   = 16'hEE;
    tick();
    write_drop   = 1'b0;
    write_enable = 1'b0;
    checks++; if (fill_count !== 4'd0) begin errors++; $display("FAIL drop_fill got %0d want 0", fill_count); end
    checks++; if (dropped_packet !== 1'b1) begin errors++; $display("FAIL drop_pulse got %0b want 1", dropped_packet); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drop_empty got %0b want 1", empty); end
    tick();
    checks++; if (dropped_packet !== 1'b0) begin errors++; $display("FAIL drop_pulse_end got %0b want 0", dropped_packet); end
    checks++; if (packet_count !== 4'd0) begin errors++; $display("FAIL drop_pkts got %0d want 0", packet_count); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) write_beat(16'h10 + 16'(i), 1'b0);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %0b want 1", full); end
    checks++; if (fill_count !== 4'd8) begin errors++; $display("FAIL ovf_fill8 got %0d want 8", fill_count); end
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL ovf_almost_full got %0b want 1", almost_full); end
    write_beat(16'h19, 1'b0);
    checks++; if (dropped_packet !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %0b want 1", dropped_packet); end
    checks++; if (fill_count !== 4'd0) begin errors++; $display("FAIL ovf_rewind got %0d want 0", fill_count); end
    write_beat(16'h1A, 1'b1);
    checks++; if (dropped_packet !== 1'b0) begin errors++; $display("FAIL ovf_pulse_once got %0b want 0", dropped_packet); end
    checks++; if ({fill_count, empty} !== {4'd0, 1'b1})
      begin errors++; $display("FAIL ovf_last_ignored got fill=%0d empty=%0b want fill=0 empty=1", fill_count, empty); end
    write_beat(16'hB1, 1'b0);
    write_beat(16'hB2, 1'b1);
    checks++; if ({fill_count, packet_count} !== {4'd2, 4'd1})
      begin errors++; $display("FAIL ovf_next_pkt got fill=%0d pkts=%0d want fill=2 pkts=1", fill_count, packet_count); end
    read_enable = 1'b1;
    tick();
    checks++; if (read_data !== 16'hB1) begin errors++; $display("FAIL ovf_rd1 got %0h want b1", read_data); end
    tick();
    read_enable = 1'b0;
    checks++; if ({read_last, read_data} !== {1'b1, 16'hB2})
      begin errors++; $display("FAIL ovf_rd2 got l=%0b d=%0h want l=1 d=b2", read_last, read_data); end
  endtask

  task automatic test_commit_read();
    write_beat(16'hC1, 1'b0);
    write_beat(16'hC2, 1'b1);
    read_enable = 1'b1;
    tick();
    checks++; if (packet_count !== 4'd1) begin errors++; $display("FAIL cr_pkts_before got %0d want 1", packet_count); end
    // Final beat C2 read while the one-beat packet 0x55 commits.
    write_enable = 1'b1;
    write_data   = 16'h55;
    write_last   = 1'b1;
    tick();
    write_enable = 1'b0;
    write_last   = 1'b0;
    checks++; if ({read_last, read_data} !== {1'b1, 16'hC2})
      begin errors++; $display("FAIL cr_rd_c2 got l=%0b d=%0h want l=1 d=c2", read_last, read_data); end
    checks++; if (packet_count !== 4'd1) begin errors++; $display("FAIL cr_pkts_same got %0d want 1", packet_count); end
    tick();
    read_enable = 1'b0;
    checks++; if ({read_data_valid, read_last, read_data} !== {1'b1, 1'b1, 16'h55})
      begin errors++; $display("FAIL cr_rd_55 got v=%0b l=%0b d=%0h want v=1 l=1 d=55", read_data_valid, read_last, read_data); end
    checks++; if (packet_count !== 4'd0) begin errors++; $display("FAIL cr_pkts_after got %0d want 0", packet_count); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k <= 20; k++) begin
      write_enable = (k < 20);
      write_data   = 16'(k);
      write_last   = 1'b1;
      read_enable  = (k > 0);
      tick();
      if (k > 0) begin
        checks++;
        if ({read_data_valid, read_data} !== {1'b1, 16'(k - 1)})
          begin errors++; $display("FAIL wrap_rd%0d got v=%0b d=%0h want v=1 d=%0h", k - 1, read_data_valid, read_data, k - 1); end
      end
    end
    write_enable = 1'b0;
    write_last   = 1'b0;
    read_enable  = 1'b0;
    checks++; if ({empty, packet_count, fill_count} !== {1'b1, 4'd0, 4'd0})
      begin errors++; $display("FAIL wrap_end got e=%0b p=%0d f=%0d want e=1 p=0 f=0", empty, packet_count, fill_count); end
  endtask

  task automatic test_reset_mid();
    write_beat(16'h60, 1'b1);
    for (int i = 1; i <= 4; i++) write_beat(16'h60 + 16'(i), 1'b0);
    checks++; if (fill_count !== 4'd5) begin errors++; $display("FAIL rm_fill_before got %0d want 5", fill_count); end
    reset        = 1'b1;
    read_enable  = 1'b1;
    write_enable = 1'b1;
    write_data   = 16'h6F;
    tick();
    reset        = 1'b0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    checks++; if ({fill_count, packet_count, empty} !== {4'd0, 4'd0, 1'b1})
      begin errors++; $display("FAIL rm_counts got f=%0d p=%0d e=%0b want f=0 p=0 e=1", fill_count, packet_count, empty); end
    checks++; if ({read_data_valid, dropped_packet} !== 2'b00)
      begin errors++; $display("FAIL rm_flags got v=%0b d=%0b want v=0 d=0", read_data_valid, dropped_packet); end
    checks++; if (read_data !== 16'h0) begin errors++; $display("FAIL rm_rdata got %0h want 0", read_data); end
    tick();
    checks++; if (dropped_packet !== 1'b0) begin errors++; $display("FAIL rm_no_pulse got %0b want 0", dropped_packet); end
    write_beat(16'h77, 1'b1);
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
    checks++; if ({read_data_valid, read_last, read_data} !== {1'b1, 1'b1, 16'h77})
      begin errors++; $display("FAIL rm_after got v=%0b l=%0b d=%0h want v=1 l=1 d=77", read_data_valid, read_last, read_data); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    write_enable = 1'b0;
    write_data   = '0;
    write_last   = 1'b0;
    write_drop   = 1'b0;
    read_enable  = 1'b0;
    test_reset();
    test_basic();
    test_drop();
    test_overflow();
    test_commit_read();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
